sys_arr: RTL and testbench

SYS_ARR -- requirements
Module: sys_arr

---
 rtl/sys_arr.sv | 208 ++++++++++++++++++++
 tb/tb_sys_arr.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_arr.sv
// Output-stationary ROWS x COLS signed MAC array: skewed operand feed, FLUSH of ROWS+COLS-1 cycles, then row-by-row drain.
// `define SYS_ARR_SAT_EN makes every accumulation saturate; otherwise accumulators wrap.
module sys_arr #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 8,
  parameter int AW   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DW-1:0]       in_a,
  input  logic [COLS*DW-1:0]       in_w,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*AW-1:0]       out_data,
  output logic [$clog2(ROWS)-1:0]  out_row,
  output logic                     out_last,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;

  localparam int CW = $clog2(ROWS + COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] FLUSH_END = CW'(ROWS + COLS - 2);
  localparam logic [RW-1:0] ROW_END   = RW'(ROWS - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            clr;

  logic signed [DW-1:0] a_sk  [ROWS];
  logic                 a_skv [ROWS];
  logic signed [DW-1:0] w_sk  [COLS];
  logic                 w_skv [COLS];
  logic signed [DW-1:0] a_pr  [ROWS][COLS-1];
  logic                 a_prv [ROWS][COLS-1];
  logic signed [DW-1:0] w_pr  [ROWS-1][COLS];
  logic                 w_prv [ROWS-1][COLS];
  logic signed [AW-1:0] acc   [ROWS][COLS];

  assign in_ready  = (state == IDLE) || (state == COMPUTE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_last  = (state == DRAIN) && (out_row == ROW_END);
  assign accept    = in_valid && in_ready;
  // the first beat of a tile zeroes every accumulator in the same edge it contributes
  assign clr       = accept && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      out_row <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt   <= '0;
          state <= in_last ? FLUSH : COMPUTE;
        end
        COMPUTE: if (accept && in_last) begin
          cnt   <= '0;
          state <= FLUSH;
        end
        FLUSH: if (cnt == FLUSH_END) state <= DRAIN;
               else cnt <= cnt + 1'b1;
        DRAIN: if (out_ready) begin
          if (out_row == ROW_END) begin
            out_row <= '0;
            state   <= IDLE;
          end else begin
            out_row <= out_row + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_sk[0]  = in_a[DW-1:0];
      assign a_skv[0] = accept;
    end else begin : g_dly
      logic signed [DW-1:0] sr  [r];
      logic                 srv [r];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < r; i++) begin
            sr[i]  <= '0;
            srv[i] <= 1'b0;
          end
        end else begin
          sr[0]  <= in_a[r*DW +: DW];
          srv[0] <= accept;
          for (int i = 1; i < r; i++) begin
            sr[i]  <= sr[i-1];
            srv[i] <= srv[i-1];
          end
        end
      end
      assign a_sk[r]  = sr[r-1];
      assign a_skv[r] = srv[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_wskew
    if (c == 0) begin : g_direct
      assign w_sk[0]  = in_w[DW-1:0];
      assign w_skv[0] = accept;
    end else begin : g_dly
      logic signed [DW-1:0] sr  [c];
      logic                 srv [c];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < c; i++) begin
            sr[i]  <= '0;
            srv[i] <= 1'b0;
          end
        end else begin
          sr[0]  <= in_w[c*DW +: DW];
          srv[0] <= accept;
          for (int i = 1; i < c; i++) begin
            sr[i]  <= sr[i-1];
            srv[i] <= srv[i-1];
          end
        end
      end
      assign w_sk[c]  = sr[c-1];
      assign w_skv[c] = srv[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [DW-1:0]   ai, wi;
      logic                   av, wv;
      logic signed [2*DW-1:0] prod;
      logic signed [AW-1:0]   base, nxt;

      if (c == 0) begin : g_ain
        assign ai = a_sk[r];
        assign av = a_skv[r];
      end else begin : g_ain
        assign ai = a_pr[r][c-1];
        assign av = a_prv[r][c-1];
      end
      if (r == 0) begin : g_win
        assign wi = w_sk[c];
        assign wv = w_skv[c];
      end else begin : g_win
        assign wi = w_pr[r-1][c];
        assign wv = w_prv[r-1][c];
      end

      // activations travel right, weights travel down, one PE per cycle
      if (c < COLS - 1) begin : g_afwd
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            a_pr[r][c]  <= '0;
            a_prv[r][c] <= 1'b0;
          end else begin
            a_pr[r][c]  <= ai;
            a_prv[r][c] <= av;
          end
        end
      end
      if (r < ROWS - 1) begin : g_wfwd
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            w_pr[r][c]  <= '0;
            w_prv[r][c] <= 1'b0;
          end else begin
            w_pr[r][c]  <= wi;
            w_prv[r][c] <= wv;
          end
        end
      end

      assign prod = ai * wi;
      assign base = clr ? '0 : acc[r][c];
`ifdef SYS_ARR_SAT_EN
      logic signed [AW:0] sum;
      assign sum = (AW+1)'(base) + (AW+1)'(prod);
      assign nxt = (sum[AW] != sum[AW-1])
                 ? (sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}})
                 : sum[AW-1:0];
`else
      assign nxt = base + AW'(prod);
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                  acc[r][c] <= '0;
        else if (av && wv)        acc[r][c] <= nxt;
        else if (clr)             acc[r][c] <= '0;
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign out_data[c*AW +: AW] = acc[out_row][c];
  end

endmodule

// File: tb/tb_sys_arr.sv
// Scoreboard bench for sys_arr (4x4, DW=8, AW=16): directed tiles plus random tiles checked against a per-beat
// arithmetic model; a monitor pops expected rows on each output handshake and checks latency, hold and stall behaviour.
module tb_sys_arr;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int AW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [R*DW-1:0]      in_a = '0;
  logic [C*DW-1:0]      in_w = '0;
  logic                 in_last = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [C*AW-1:0]      out_data;
  logic [1:0]           out_row;
  logic                 out_last;
  logic                 busy;

  sys_arr #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_edge = 0;
  int stall = 0;

  logic [C*AW-1:0] exp_q[$];
  int              erow_q[$];
  int              ta[8][R];
  int              tw[8][C];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // reference: each output lane is the ordered sum of a*w over the tile's beats, wrapped or clamped every step
  task automatic push_expect(input int nb);
    longint s;
    longint mx = (longint'(1) <<< (AW-1)) - 1;
    longint mn = -(longint'(1) <<< (AW-1));
    logic signed [AW-1:0] acc;
    logic [C*AW-1:0] v;
    for (int r = 0; r < R; r++) begin
      v = '0;
      for (int c = 0; c < C; c++) begin
        acc = '0;
        for (int b = 0; b < nb; b++) begin
          s = longint'(acc) + longint'(ta[b][r]) * longint'(tw[b][c]);
`ifdef SYS_ARR_SAT_EN
          if (s > mx) s = mx;
          if (s < mn) s = mn;
`endif
          acc = s[AW-1:0];
        end
        v[c*AW +: AW] = acc;
      end
      exp_q.push_back(v);
      erow_q.push_back(r);
    end
  endtask

  // sends n beats; only a complete tile (last flagged) is expected to produce rows
  task automatic send_tile(input int nb, input int nsend, input bit complete, input bit gaps);
    int t;
    if (complete) push_expect(nb);
    for (int b = 0; b < nsend; b++) begin
      if (gaps && b > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = complete && (b == nsend - 1);
      for (int r = 0; r < R; r++) in_a[r*DW +: DW] = DW'(ta[b][r]);
      for (int c = 0; c < C; c++) in_w[c*DW +: DW] = DW'(tw[b][c]);
      t = 0;
      while (!in_ready && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (t >= 400) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic fill(input int nb, input int a0, input int w0, input bit arow);
    for (int b = 0; b < nb; b++) begin
      for (int r = 0; r < R; r++) ta[b][r] = arow ? r + 1 : a0;
      for (int c = 0; c < C; c++) tw[b][c] = w0;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_row", 64'(out_row), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
  endtask

  // monitor / scoreboard
  initial begin
    logic            ov_prev = 1'b0;
    logic            hold_prev = 1'b0;
    logic [C*AW-1:0] hold_d = '0;
    logic [1:0]      hold_r = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        ov_prev = 1'b0;
        hold_prev = 1'b0;
        out_ready = 1'b0;
      end else begin
        if (in_valid && in_ready && in_last) last_edge = cyc + 1;
        if (out_valid && stall > 0) begin
          out_ready = 1'b0;
          stall--;
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_busy", 64'(busy), 64'd1);
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (hold_prev && out_valid) begin
          chk("hold_data", 64'(out_data), 64'(hold_d));
          chk("hold_row", 64'(out_row), 64'(hold_r));
        end
        if (out_valid && !ov_prev) chk("drain_latency", 64'(cyc - last_edge), 64'(R + C - 1));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_row", 64'(out_valid), 64'd0);
          end else begin
            int er;
            logic [C*AW-1:0] ed;
            ed = exp_q.pop_front();
            er = erow_q.pop_front();
            chk("row_data", 64'(out_data), 64'(ed));
            chk("row_index", 64'(out_row), 64'(er));
            chk("row_last", 64'(out_last), 64'(er == R - 1));
          end
        end
        hold_prev = out_valid && !out_ready;
        hold_d    = out_data;
        hold_r    = out_row;
        ov_prev   = out_valid;
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    fill(3, 0, 1, 1'b1);               // rows read 3*(r+1)
    send_tile(3, 3, 1'b1, 1'b0);

    fill(1, -2, 3, 1'b0);              // single-beat tile goes straight to FLUSH
    send_tile(1, 1, 1'b1, 1'b0);
    chk("single_beat_flush_ready", 64'(in_ready), 64'd0);
    chk("single_beat_flush_busy", 64'(busy), 64'd1);

    stall = 5;
    fill(2, 7, -5, 1'b0);
    send_tile(2, 2, 1'b1, 1'b0);

    fill(3, 0, 1, 1'b1);               // same tile with bubbles between beats
    send_tile(3, 3, 1'b1, 1'b1);

    fill(3, -128, -128, 1'b0);         // wraps to -16384, saturates to 32767
    send_tile(3, 3, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      int nb;
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        for (int r = 0; r < R; r++) ta[b][r] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < C; c++) tw[b][c] = int'($urandom_range(0, 255)) - 128;
      end
      if (k == 3) stall = $urandom_range(1, 6);
      send_tile(nb, nb, 1'b1, 1'($urandom_range(0, 1)));
    end

    // abort a tile mid-compute, then run a fresh 1-beat tile
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    fill(3, 9, 9, 1'b0);
    send_tile(3, 2, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fill(1, 1, 1, 1'b0);
    send_tile(1, 1, 1'b1, 1'b0);

    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("final_idle_busy", 64'(busy), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
